// File: rtl/clock_pkg.sv
// Shared constants for the time display scan path.
// Contents:
//   SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-low segment codes {g,f,e,d,c,b,a}
//   DIG_*                           : digit slot indices, seconds ones = 0
//   SEC_MAX, MIN_MAX, HOUR_MAX      : largest legal value of each field
//   time_t                          : one captured time value
package clock_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

endpackage

// File: rtl/time_display_scan_seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
// Ports:
//   bcd_i  [3:0] : BCD digit 0..9 (other codes blank the digit)
//   dash_i       : show a dash instead of the digit
//   seg_o  [6:0] : segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for HH:MM:SS.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sec, min, hour  : binary time fields
//   blink_sel [1:0] : field to blink (00 none, 01 sec, 10 min, 11 hour)
//   an  [5:0]       : digit enables, active-low, bit i = digit i
//   seg [6:0]       : segments {g,f,e,d,c,b,a}, active-low
//   dp              : colon, active-low
module time_display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic [1:0] blink_sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  time_t         snap_q, snap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, wrap;
  logic [3:0]    sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic          sec_bad, min_bad, hour_bad;
  logic [3:0]    dig_bcd;
  logic          dig_dash;
  logic [1:0]    dig_field;
  logic [6:0]    seg_w;
  logic          blank;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == DIG_HOUR_TENS);

  assign sec_tens  = 4'(snap_q.sec / 6'd10);
  assign sec_ones  = 4'(snap_q.sec % 6'd10);
  assign min_tens  = 4'(snap_q.min / 6'd10);
  assign min_ones  = 4'(snap_q.min % 6'd10);
  assign hour_tens = 4'(snap_q.hour / 5'd10);
  assign hour_ones = 4'(snap_q.hour % 5'd10);
  assign sec_bad   = snap_q.sec  > SEC_MAX;
  assign min_bad   = snap_q.min  > MIN_MAX;
  assign hour_bad  = snap_q.hour > HOUR_MAX;

  // Digit selected by the current index; field code matches blink_sel encoding.
  always_comb begin
    dig_bcd   = 4'd0;
    dig_dash  = 1'b0;
    dig_field = 2'b00;
    case (idx_q)
      DIG_SEC_ONES:  begin dig_bcd = sec_ones;  dig_dash = sec_bad;  dig_field = 2'b01; end
      DIG_SEC_TENS:  begin dig_bcd = sec_tens;  dig_dash = sec_bad;  dig_field = 2'b01; end
      DIG_MIN_ONES:  begin dig_bcd = min_ones;  dig_dash = min_bad;  dig_field = 2'b10; end
      DIG_MIN_TENS:  begin dig_bcd = min_tens;  dig_dash = min_bad;  dig_field = 2'b10; end
      DIG_HOUR_ONES: begin dig_bcd = hour_ones; dig_dash = hour_bad; dig_field = 2'b11; end
      DIG_HOUR_TENS: begin dig_bcd = hour_tens; dig_dash = hour_bad; dig_field = 2'b11; end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .bcd_i  (dig_bcd),
    .dash_i (dig_dash),
    .seg_o  (seg_w)
  );

  assign blank = phase_q && (blink_sel != 2'b00) && (blink_sel == dig_field);

  // The output registers capture the digit at idx_q on the tick that moves
  // the index on, so the snapshot taken at the 5->0 wrap first shows on digit 0.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    snap_d  = snap_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (tick) begin
      idx_d = (idx_q == DIG_HOUR_TENS) ? DIG_SEC_ONES : idx_q + 3'd1;
      an_d  = blank ? 6'b111111 : ~(6'b000001 << idx_q);
      seg_d = seg_w;
      dp_d  = !(((idx_q == DIG_MIN_ONES) || (idx_q == DIG_HOUR_ONES)) && !snap_q.sec[0]);
    end
    if (wrap) begin
      snap_d = '{hour: hour, min: min, sec: sec};
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= DIG_SEC_ONES;
      frame_q <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      an_q    <= 6'b111111;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
module tb_time_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [1:0] blink_sel;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  time_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk       (clk),
    .rst       (rst),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .blink_sel (blink_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles since reset release, frame-level snapshot.
  int         n;
  int         snap_s, snap_m, snap_h;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic logic [6:0] seg_code(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_edge();
    int k, d, f, v, lim, phase, fld;
    if (rst) begin
      n = 0;
      snap_s = 0; snap_m = 0; snap_h = 0;
      e_an = 6'b111111; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      n++;
      if (n % SD == 0) begin
        k   = n / SD;
        d   = (k - 1) % 6;
        f   = (k - 1) / 6;
        fld = d / 2;
        v   = (fld == 0) ? snap_s : (fld == 1) ? snap_m : snap_h;
        lim = (fld == 2) ? 23 : 59;
        if (v > lim) e_seg = 7'b0111111;
        else         e_seg = seg_code((d % 2 == 1) ? v / 10 : v % 10);
        e_dp  = !((d == 2 || d == 4) && (snap_s % 2 == 0));
        phase = (f / BF) % 2;
        if (phase == 1 && int'(blink_sel) == fld + 1) e_an = 6'b111111;
        else e_an = 6'b111111 ^ (6'b000001 << d);
        if (d == 5) begin
          snap_s = int'(sec); snap_m = int'(min); snap_h = int'(hour);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an", {1'b0, an}, {1'b0, e_an});
    chk("seg", seg, e_seg);
    chk("dp", {6'b0, dp}, {6'b0, e_dp});
  endtask

  task automatic run(input int cyc);
    repeat (cyc) step();
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    run(cyc);
    rst = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  // Bounded wait for a given digit enable pattern, then a fixed-value check.
  task automatic spot(input string tag, input logic [5:0] an_pat, input logic [6:0] seg_exp,
                      input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (an === an_pat && n > SD * 6) found = 1'b1;
    end
    checks++;
    assert (found)
    else begin
      failures++;
      $error("FAIL %s_timeout observed=none expected=an_%b", tag, an_pat);
    end
    if (found) chk(tag, seg, seg_exp);
  endtask

  initial begin
    rst = 1'b1; blink_sel = 2'b00;
    set_time(0, 0, 0);
    n = 0; snap_s = 0; snap_m = 0; snap_h = 0;
    e_an = 6'b111111; e_seg = 7'h7F; e_dp = 1'b1;

    // Reset, then 12:34:56 (frame 0 still shows zeros)
    do_reset(3);
    set_time(12, 34, 56);
    run(SD * 6 * 3);
    spot("sec_tens_5", 6'b111101, 7'b0010010, 60);
    spot("hour_tens_1", 6'b011111, 7'b1111001, 60);

    // Snapshot integrity: sec 58 -> 59 while digit 2 of frame 1 is active
    do_reset(2);
    set_time(5, 0, 58);
    run(SD * 9 + 1);
    sec = 6'd59;
    run(SD * 6 * 3);

    // Blink minutes across six frames
    do_reset(2);
    blink_sel = 2'b10;
    set_time(7, 45, 20);
    run(SD * 6 * 7);
    blink_sel = 2'b00;

    // Out-of-range fields
    do_reset(2);
    set_time(24, 37, 60);
    run(SD * 6 * 2);
    spot("sec_dash", 6'b111110, 7'b0111111, 60);
    spot("min_ones_7", 6'b111011, 7'b1111000, 60);

    // Mid-scan reset while digit 3 is active
    do_reset(2);
    set_time(9, 8, 7);
    run(SD * 6 + SD * 4 + 1);
    do_reset(1);
    run(SD * 6 * 2);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 4) == 0)
          set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        else
          set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      end
      if ($urandom_range(0, 14) == 0) blink_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(SD * 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
